// File: rtl/lsu_mem_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Brief    : Shared types, funct3 constants, register-file write-mode codes
//             and the command decoder for the load/store unit.
//  Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } lsu_state_e;

  // RISC-V funct3 values for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size carried in funct3[1:0]
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  // Register-file write-mode codes; the register file does the final extension
  localparam logic [2:0] WM_NONE = 3'b000;
  localparam logic [2:0] WM_W    = 3'b001;
  localparam logic [2:0] WM_H    = 3'b010;
  localparam logic [2:0] WM_B    = 3'b011;
  localparam logic [2:0] WM_HU   = 3'b110;
  localparam logic [2:0] WM_BU   = 3'b111;

  typedef struct packed {
    logic       legal;
    logic       misaligned;
    logic [2:0] code;
  } lsu_dec_t;

  // Classify a command: legality of funct3, alignment, and load write-mode code
  function automatic lsu_dec_t lsu_decode(input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    lsu_dec_t d;
    d.legal      = 1'b0;
    d.misaligned = 1'b0;
    d.code       = WM_NONE;
    case (funct3)
      F3_B: begin
        d.legal = 1'b1;
        d.code  = is_store ? WM_NONE : WM_B;
      end
      F3_H: begin
        d.legal      = 1'b1;
        d.misaligned = addr_lo[0];
        d.code       = is_store ? WM_NONE : WM_H;
      end
      F3_W: begin
        d.legal      = 1'b1;
        d.misaligned = |addr_lo;
        d.code       = is_store ? WM_NONE : WM_W;
      end
      F3_BU: begin
        d.legal = ~is_store;
        d.code  = is_store ? WM_NONE : WM_BU;
      end
      F3_HU: begin
        d.legal      = ~is_store;
        d.misaligned = addr_lo[0];
        d.code       = is_store ? WM_NONE : WM_HU;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_port_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_if
//  Brief    : Data-memory request/ready bus between the LSU and memory.
//  Revision : 1.0 - initial release
// ============================================================================
interface lsu_mem_if #(
  parameter int DATA_WIDTH = 32
);
  logic                      req;
  logic                      we;
  logic [DATA_WIDTH-1:0]     addr;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      ready;

  // LSU side
  modport master (
    output req, we, addr, wstrb, wdata,
    input  rdata, ready
  );

  // Memory side
  modport slave (
    input  req, we, addr, wstrb, wdata,
    output rdata, ready
  );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_port_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Brief    : Combinational byte-lane logic: store strobes, store data
//             replication and load right-shift.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  // Store lanes: replicate the datum so any lane selected by the strobe is correct
  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = 32'd0;
    if (is_store_i) begin
      case (size_i)
        SZ_BYTE: begin
          wstrb_o = 4'b0001 << addr_lo_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        SZ_HALF: begin
          wstrb_o = 4'b0011 << addr_lo_i;
          wdata_o = {2{wdata_i[15:0]}};
        end
        default: begin
          wstrb_o = 4'b1111;
          wdata_o = wdata_i;
        end
      endcase
    end
  end

  // Load lanes: right-justify; upper bits are left for the register file to extend
  assign rdata_o = rdata_i >> {addr_lo_i, 3'b000};

endmodule
`default_nettype wire

// File: rtl/lsu_mem_port.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_port
//  Brief    : Multi-cycle load/store unit with req/ready memory handshake,
//             alignment checking, timeout and register-file write-mode output.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [2:0]            rd_we,
  lsu_mem_if.master             mem
);

  // Last REQ cycle index before giving up (counter holds cycles already waited)
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  lsu_state_e            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  is_store_q;
  logic [1:0]            size_q;
  logic [2:0]            code_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic                  latch_en;
  logic                  capture;
  logic                  in_req;
  lsu_dec_t              dec;
  logic [3:0]            al_wstrb;
  logic [DATA_WIDTH-1:0] al_wdata;
  logic [DATA_WIDTH-1:0] al_rdata;

  assign dec = lsu_decode(is_store, funct3, addr[1:0]);

  lsu_align u_align (
    .is_store_i (is_store_q),
    .size_i     (size_q),
    .addr_lo_i  (addr_q[1:0]),
    .wdata_i    (wdata_q),
    .rdata_i    (mem.rdata),
    .wstrb_o    (al_wstrb),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata)
  );

  // State, timeout counter, latched command and load result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      is_store_q <= 1'b0;
      size_q     <= 2'b00;
      code_q     <= WM_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        is_store_q <= is_store;
        size_q     <= funct3[1:0];
        code_q     <= dec.code;
        addr_q     <= addr;
        wdata_q    <= wdata;
      end
      if (capture) begin
        rd_data_q <= al_rdata;
      end
    end
  end

  // Next-state logic; ready beats the timeout when both land in the same cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    capture  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          latch_en = 1'b1;
          cnt_d    = 8'd0;
          state_d  = (!dec.legal || dec.misaligned) ? ST_ERR : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem.ready) begin
          capture = ~is_store_q;
          state_d = ST_RESP;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs decode from the state register only
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign err     = (state_q == ST_ERR);
  assign rd_we   = (state_q == ST_RESP) ? code_q : WM_NONE;
  assign rd_data = rd_data_q;

  // Memory bus is active only in REQ and quiet otherwise
  assign in_req    = (state_q == ST_REQ);
  assign mem.req   = in_req;
  assign mem.we    = in_req & is_store_q;
  assign mem.addr  = in_req ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
  assign mem.wstrb = in_req ? al_wstrb : 4'b0000;
  assign mem.wdata = in_req ? al_wdata : '0;

endmodule
`default_nettype wire

// File: doc/lsu_mem_port.md
# lsu_mem_port

Multi-cycle load/store unit between the single-cycle datapath and the data memory. It accepts one load or store per command, performs byte-lane alignment and strobe generation, and runs a req/ready handshake to memory. For loads it returns the lane-shifted data together with the register-file write-mode code (001 word, 010 lh, 011 lb, 110 lhu, 111 lbu), so the register file's write port performs the final sign or zero extension.

## Interface
- `DATA_WIDTH`, 32: data and address width; only 32 is supported.
- `TIMEOUT`, 255: maximum number of REQ cycles without `mem_ready` before the access aborts; 8-bit counter.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: command valid; sampled only in IDLE.
- `is_store`, input, 1: 1 = store, 0 = load.
- `funct3`, input, 3: RISC-V funct3. Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Stores: 000 sb, 001 sh, 010 sw.
- `addr`, input, 32: byte address.
- `wdata`, input, 32: store data (rs2).
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: single-cycle completion pulse.
- `err`, output, 1: valid with `done`; set on misaligned access, illegal funct3, or timeout.
- `rd_data`, output, 32: load result, right-justified, upper bits unextended; held until the next `done`.
- `rd_we`, output, 3: register-file write-mode code, valid only during `done`; 000 at all other times and for stores and errors.
- `mem_req`, output, 1: memory request.
- `mem_we`, output, 1: memory write enable.
- `mem_addr`, output, 32: word address, `{addr[31:2], 2'b00}`.
- `mem_wstrb`, output, 4: byte strobes.
- `mem_wdata`, output, 32: lane-replicated store data.
- `mem_rdata`, input, 32: read data; valid when `mem_ready` is high.
- `mem_ready`, input, 1: request accepted and completed this cycle.

## Operation
- **States:** IDLE, REQ, RESP, ERR.
- **IDLE with `start`:**
  - Latch `is_store`, `funct3`, `addr` and `wdata`.
  - Illegal funct3 (load 011/110/111, store 011 or above) goes to ERR.
  - Misaligned access (half with `addr[0]`=1, word with `addr[1:0]`≠0) goes to ERR.
  - Otherwise go to REQ.
- **REQ:**
  - `mem_req`=1, with `mem_we`, `mem_addr`, `mem_wstrb` and `mem_wdata` driven from the latched command and held stable.
  - On `mem_ready`, capture `mem_rdata` and go to RESP.
  - When the timeout counter reaches `TIMEOUT`, go to ERR.
- **RESP:** `done`=1, `rd_we` set to the code below (loads only), then go to IDLE.
- **ERR:** `done`=1, `err`=1, `rd_we`=000, no memory access, then go to IDLE.
- **Store strobes:**
  - sb: `1<<addr[1:0]`, data `{4{wdata[7:0]}}`.
  - sh: `4'b0011<<addr[1:0]`, data `{2{wdata[15:0]}}`.
  - sw: `4'b1111`, data `wdata`.
- **Loads:** `mem_wstrb`=0, `mem_we`=0; `rd_data = mem_rdata >> (8*addr[1:0])`.
- **Code map:** lw→001, lh→010, lb→011, lhu→110, lbu→111.
- **Ignored commands:** `start` outside IDLE is ignored, not queued. `start` in the same cycle as `done` is also ignored.

## Timing
- **Reset values:** state IDLE; all outputs 0; `rd_data`=0; timeout counter 0.
- **Asserting `rst_n` low mid-access:** drops `mem_req` asynchronously; no `done` is produced for the aborted command.
- **Command latency:** `start` at edge N gives `mem_req` high in cycle N+1.
- **Response latency:** `mem_ready` at edge M gives `done` in cycle M+1.
- **Minimum latency:** 3 cycles from `start` to `done` (memory ready in the first REQ cycle).
- **Error latency:** 2 cycles from `start` to `done`/`err`.
- **Timeout counter:** cleared on REQ entry, increments each REQ cycle without `mem_ready`. A `mem_ready` in the same cycle the count reaches `TIMEOUT` wins, and the access completes normally.
- **Registered outputs:** `busy`, `done`, `err` and `rd_we` decode directly from the state register; there is no combinational path from `start` to any output.

## Structure
- **Package `lsu_pkg`:**
  - state enum.
  - funct3 constants.
  - register-file write-mode codes: `WM_NONE`=000, `WM_W`=001, `WM_H`=010, `WM_B`=011, `WM_HU`=110, `WM_BU`=111.
  - function `lsu_decode` returning legal/misaligned/code.
- **Sub-module `lsu_align`:** purely combinational; strobe generation, store replication and load shift. The FSM stays in `lsu_mem_port`.

## Test plan
1. **Store byte:** sb, addr=0x103, wdata=0x000000A5, `mem_ready` in the first REQ cycle → `mem_addr`=0x100, `mem_wstrb`=1000, `mem_wdata`=0xA5A5A5A5, `done` 3 cycles after `start`, `rd_we`=000.
2. **Load half:** lh, addr=0x202, `mem_rdata`=0x8001_1234 → `rd_data` low 16 bits = 0x8001, `rd_we`=010. Repeat as lhu → `rd_we`=110.
3. **Misaligned load word:** lw, addr=0x1 → `mem_req` never rises, `done`=`err`=1 2 cycles after `start`. Load funct3=011 behaves the same.
4. **Wait states:** `mem_ready` delayed 5 cycles → `mem_req` and address held constant, `done` exactly 1 cycle after `mem_ready`. `start` pulsed while busy is ignored.
5. **Timeout:** `TIMEOUT`=4, `mem_ready` held low → `err` after 4 REQ cycles. `mem_ready` arriving on the 4th cycle → normal completion.
6. **Reset in REQ:** assert `rst_n` low in REQ → `mem_req` falls before the next edge, all outputs 0. A new lbu at addr=0x3 with `mem_rdata`=0xFF000000 then completes with `rd_data` low byte = 0xFF, `rd_we`=111.
